// File: rtl/popcount30_neuron_seq_if.sv
// Bundle of the sequencer's control, weight-ROM, popcount and result handshake signals.
// The slave modport is the sequencer; the master modport is its environment.
interface popcount30_neuron_seq_if #(
    parameter int N_NEURONS = 4,
    parameter int THR_W     = 6
);
    localparam int AW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic                    start;
    logic [29:0]             x_in;
    logic                    busy;
    logic                    w_rd;
    logic [AW-1:0]           w_addr;
    logic [29:0]             w_pos;
    logic [29:0]             w_neg;
    logic [THR_W-1:0]        w_thr;
    logic [29:0]             pc_a;
    logic [4:0]              pc_out;
    logic                    out_valid;
    logic                    out_ready;
    logic [N_NEURONS-1:0]    act_out;

    modport slave (
        input  start, x_in, w_pos, w_neg, w_thr, pc_out, out_ready,
        output busy, w_rd, w_addr, pc_a, out_valid, act_out
    );

    modport master (
        output start, x_in, w_pos, w_neg, w_thr, pc_out, out_ready,
        input  busy, w_rd, w_addr, pc_a, out_valid, act_out
    );
endinterface

// File: rtl/popcount30_neuron_seq.sv
// Time-shares one external 30-input popcount unit across N_NEURONS ternary neurons.
// Optional feature: define POPCOUNT_NEURON_CLAMP_EN to clamp popcount results of 31 down to 30.
module popcount30_neuron_seq #(
    parameter int N_NEURONS = 4,
    parameter int THR_W     = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    popcount30_neuron_seq_if.slave bus
);
    localparam int AW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_POS   = 3'd2,
        S_NEG   = 3'd3,
        S_EVAL  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [29:0]            x_q, x_d;
    logic [AW-1:0]          n_q, n_d;
    logic [4:0]             pos_q, pos_d;
    logic [4:0]             neg_q, neg_d;
    logic [N_NEURONS-1:0]   act_q, act_d;
    logic                   busy_q, busy_d;
    logic                   w_rd_q, w_rd_d;
    logic [AW-1:0]          w_addr_q, w_addr_d;
    logic                   out_valid_q, out_valid_d;

    logic [29:0]            pc_a_c;
    logic [4:0]             pc_sat;
    logic signed [5:0]      diff;
    logic signed [THR_W-1:0] diff_ext;
    logic                   act;

`ifdef POPCOUNT_NEURON_CLAMP_EN
    // An approximate unit may report 31 for a 30-bit operand; bound that error.
    assign pc_sat = (bus.pc_out == 5'd31) ? 5'd30 : bus.pc_out;
`else
    assign pc_sat = bus.pc_out;
`endif

    assign diff     = $signed({1'b0, pos_q}) - $signed({1'b0, neg_q});
    assign diff_ext = THR_W'(diff);
    assign act      = (diff_ext >= $signed(bus.w_thr));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        n_d     = n_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        act_d   = act_q;
        pc_a_c  = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x_d     = bus.x_in;
                    n_d     = '0;
                    act_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_POS;
            S_POS: begin
                pc_a_c  = x_q & bus.w_pos;
                pos_d   = pc_sat;
                state_d = S_NEG;
            end
            S_NEG: begin
                pc_a_c  = x_q & bus.w_neg;
                neg_d   = pc_sat;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                act_d[n_q] = act;
                if (n_q == AW'(N_NEURONS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    n_d     = n_q + AW'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                // start is deliberately not looked at here, even alongside out_ready.
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered copies of what the next state implies, so they line up with it.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        w_rd_d      = (state_d == S_FETCH);
        w_addr_d    = n_d;
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            n_q         <= '0;
            pos_q       <= '0;
            neg_q       <= '0;
            act_q       <= '0;
            busy_q      <= 1'b0;
            w_rd_q      <= 1'b0;
            w_addr_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            n_q         <= n_d;
            pos_q       <= pos_d;
            neg_q       <= neg_d;
            act_q       <= act_d;
            busy_q      <= busy_d;
            w_rd_q      <= w_rd_d;
            w_addr_q    <= w_addr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.w_rd      = w_rd_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.act_out   = act_q;
    assign bus.pc_a      = pc_a_c;
endmodule

// File: tb/tb_popcount30_neuron_seq.sv
// Self-checking bench: weight ROM and popcount stub models, table vectors, random layers, corner sequences.
module tb_popcount30_neuron_seq;
    localparam int N  = 4;
    localparam int TW = 6;

    logic clk;
    logic rst_n;
    int   total_cnt;
    int   pass_cnt;
    logic force_mode;

    logic [29:0]   rom_pos [N];
    logic [29:0]   rom_neg [N];
    logic [TW-1:0] rom_thr [N];

    popcount30_neuron_seq_if #(.N_NEURONS(N), .THR_W(TW)) ifc ();

    popcount30_neuron_seq #(.N_NEURONS(N), .THR_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight ROM: data appears the cycle after a read strobe and is held until the next one.
    always @(posedge clk) begin
        if (ifc.w_rd) begin
            ifc.w_pos <= rom_pos[ifc.w_addr];
            ifc.w_neg <= rom_neg[ifc.w_addr];
            ifc.w_thr <= rom_thr[ifc.w_addr];
        end
    end

    // Ideal popcount, or a faulty unit that reports 31 for any nonzero operand.
    assign ifc.pc_out = force_mode ? ((ifc.pc_a != 30'd0) ? 5'd31 : 5'd0)
                                   : 5'($countones(ifc.pc_a));

    typedef struct {
        logic [29:0]         x;
        logic [N-1:0][29:0]  wp;
        logic [N-1:0][29:0]  wn;
        logic [N-1:0][TW-1:0] thr;
        logic [N-1:0]        exp_act;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total_cnt++;
        if (got === req) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, got, req);
    endtask

    function automatic vec_t mk(input logic [29:0] x, input logic [29:0] wp, input logic [29:0] wn,
                                input logic [TW-1:0] thr, input logic [N-1:0] e);
        vec_t v;
        v.x = x;
        for (int i = 0; i < N; i++) begin
            v.wp[i]  = wp;
            v.wn[i]  = wn;
            v.thr[i] = thr;
        end
        v.exp_act = e;
        return v;
    endfunction

    task automatic load_rom(input vec_t v);
        for (int i = 0; i < N; i++) begin
            rom_pos[i] = v.wp[i];
            rom_neg[i] = v.wn[i];
            rom_thr[i] = v.thr[i];
        end
    endtask

    // Reference: activation = (popcount(x&pos) - popcount(x&neg)) >= signed threshold.
    function automatic logic [N-1:0] ref_act(input logic [29:0] x);
        logic [N-1:0] r;
        int p, q, t;
        for (int i = 0; i < N; i++) begin
            p = $countones(x & rom_pos[i]);
            q = $countones(x & rom_neg[i]);
            t = $signed(rom_thr[i]);
            r[i] = ((p - q) >= t);
        end
        return r;
    endfunction

    task automatic start_layer(input logic [29:0] x);
        @(negedge clk);
        ifc.x_in  = x;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ifc.out_valid && k < 100);
        chk("latency", 32'(k), 32'd17);
    endtask

    task automatic release_done();
        @(negedge clk);
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        chk("release_busy", 32'(ifc.busy), 32'd0);
        chk("release_valid", 32'(ifc.out_valid), 32'd0);
    endtask

    task automatic run_layer(input string name, input logic [29:0] x, input logic [N-1:0] e);
        int k;
        start_layer(x);
        wait_valid(k);
        chk(name, 32'(ifc.act_out), 32'(e));
        release_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
        chk({tag, "_w_rd"}, 32'(ifc.w_rd), 32'd0);
        chk({tag, "_w_addr"}, 32'(ifc.w_addr), 32'd0);
        chk({tag, "_pc_a"}, 32'(ifc.pc_a), 32'd0);
        chk({tag, "_out_valid"}, 32'(ifc.out_valid), 32'd0);
        chk({tag, "_act_out"}, 32'(ifc.act_out), 32'd0);
    endtask

    initial begin
        int k;
        logic [N-1:0] held;
        logic [29:0] xr;
        logic exp_force;
        total_cnt     = 0;
        pass_cnt      = 0;
        force_mode    = 1'b0;
        rst_n         = 1'b0;
        ifc.start     = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.x_in      = '0;

        vecs[0] = mk(30'h3FFFFFFF, 30'h0000FFFF, 30'h000000FF, 6'd8,  4'hF);
        vecs[1] = mk(30'h3FFFFFFF, 30'h0000FFFF, 30'h000000FF, 6'd9,  4'h0);
        vecs[2] = mk(30'h0,        30'h0,        30'h0,        6'h3F, 4'hF);
        vecs[3] = mk(30'h0,        30'h0,        30'h0,        6'd1,  4'h0);
        vecs[4] = mk(30'h3FFFFFFF, 30'h0,        30'h0,        6'd0,  4'b1011);
        vecs[4].wp[0] = 30'h3FFFFFFF; vecs[4].thr[0] = 6'd30;
        vecs[4].wn[1] = 30'h3FFFFFFF; vecs[4].thr[1] = 6'h22;
        vecs[4].wp[2] = 30'h0000000F; vecs[4].wn[2] = 30'h0000000F; vecs[4].thr[2] = 6'd1;

        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            load_rom(vecs[v]);
            run_layer($sformatf("vec%0d_act", v), vecs[v].x, vecs[v].exp_act);
            $display("vector %0d x=%h act_expected=%h", v, vecs[v].x, vecs[v].exp_act);
        end

        // Cycle-accurate walk through one layer; prior act_out is nonzero, so clearing is visible.
        load_rom(vecs[0]);
        start_layer(30'h3FFFFFFF);
        for (int e = 1; e <= 17; e++) begin
            @(negedge clk);
            if (e == 1) begin
                chk("clear_act_on_start", 32'(ifc.act_out), 32'd0);
                chk("busy_rise", 32'(ifc.busy), 32'd1);
            end
            chk($sformatf("w_rd_e%0d", e), 32'(ifc.w_rd),
                32'(e == 1 || e == 5 || e == 9 || e == 13));
            if (ifc.w_rd) chk($sformatf("w_addr_e%0d", e), 32'(ifc.w_addr), 32'((e - 1) / 4));
            chk($sformatf("pc_a_nz_e%0d", e), 32'(ifc.pc_a != 30'd0),
                32'(e < 17 && (e % 4 == 2 || e % 4 == 3)));
            chk($sformatf("out_valid_e%0d", e), 32'(ifc.out_valid), 32'(e == 17));
        end
        release_done();
        $display("cycle walk done");

        // Consumer stalls for 5 cycles while start is pulsed; result must hold.
        load_rom(vecs[4]);
        start_layer(30'h3FFFFFFF);
        wait_valid(k);
        held = ifc.act_out;
        chk("stall_first_act", 32'(held), 32'hB);
        for (int c = 0; c < 5; c++) begin
            ifc.start = 1'b1;
            @(negedge clk);
            chk($sformatf("stall_valid_%0d", c), 32'(ifc.out_valid), 32'd1);
            chk($sformatf("stall_act_%0d", c), 32'(ifc.act_out), 32'(held));
            chk($sformatf("stall_busy_%0d", c), 32'(ifc.busy), 32'd1);
        end
        ifc.start = 1'b0;
        release_done();
        @(negedge clk);
        chk("idle_after_release", 32'(ifc.busy), 32'd0);
        $display("handshake stall done");

        // start together with out_ready in DONE: start must be dropped.
        load_rom(vecs[0]);
        start_layer(30'h3FFFFFFF);
        wait_valid(k);
        @(negedge clk);
        ifc.out_ready = 1'b1;
        ifc.start     = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        ifc.start     = 1'b0;
        chk("simul_busy", 32'(ifc.busy), 32'd0);
        @(negedge clk);
        chk("simul_still_idle", 32'(ifc.busy), 32'd0);
        run_layer("after_simul_act", 30'h3FFFFFFF, 4'hF);
        $display("simultaneous start/ready done");

        // Reset in NEG of neuron 2, then a clean rerun.
        load_rom(vecs[4]);
        start_layer(30'h3FFFFFFF);
        for (int e = 1; e <= 11; e++) @(negedge clk);
        chk("mid_neg_busy", 32'(ifc.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_layer("after_reset_act", 30'h3FFFFFFF, 4'hB);
        $display("mid-layer reset done");

        // Popcount unit over-reporting 31 on the positive pass.
        force_mode = 1'b1;
        load_rom(mk(30'h3FFFFFFF, 30'h3FFFFFFF, 30'h0, 6'd31, 4'h0));
`ifdef POPCOUNT_NEURON_CLAMP_EN
        exp_force = 1'b0;
`else
        exp_force = 1'b1;
`endif
        run_layer("clamp_act", 30'h3FFFFFFF, {N{exp_force}});
        force_mode = 1'b0;
        $display("over-reporting popcount done");

        for (int r = 0; r < 12; r++) begin
            xr = 30'($urandom);
            for (int i = 0; i < N; i++) begin
                rom_pos[i] = 30'($urandom) & 30'($urandom);
                rom_neg[i] = 30'($urandom) & 30'($urandom);
                rom_thr[i] = TW'($urandom_range(0, 63));
                if (r < 4) rom_thr[i] = TW'($urandom_range(0, 6)) - TW'(3);
            end
            run_layer($sformatf("rand%0d_act", r), xr, ref_act(xr));
            $display("random %0d x=%h act_expected=%h", r, xr, ref_act(xr));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
